// File: rtl/sigma_delta_adc_ctrl.sv
// Capture controller for a sigma-delta ADC: settle/discard, burst or continuous capture,
// and a first-word-fall-through output FIFO with a sticky overflow flag.
module sigma_delta_adc_ctrl #(
    parameter int WDTH   = 16,
    parameter int SETTLE = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_stop,
    input  logic                       cfg_cont,
    input  logic [15:0]                cfg_burst_len,
    output logic                       adc_rst,
    input  logic signed [WDTH-1:0]     adc_s_output,
    input  logic                       adc_valid,
    output logic signed [WDTH-1:0]     m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN, ST_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SW-1:0]          settle_cnt;
    logic [15:0]            cap_cnt;
    logic                   cont_q;
    logic [15:0]            len_q;
    logic                   start_lat, settle_inc, cap_inc;
    logic                   zero_burst;
    logic                   full, pop, push, sample_in, ovf_set;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic signed [WDTH-1:0] mem [DEPTH];

    assign zero_burst = !cont_q && (len_q == 16'd0);
    assign full       = (fifo_level == FULL_LVL);
    assign pop        = m_valid && m_ready;
    assign sample_in  = (state == ST_RUN) && adc_valid;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push       = sample_in && (!full || pop);
    assign ovf_set    = sample_in && full && !pop;

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign m_valid = (fifo_level != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt  = state;
        start_lat  = 1'b0;
        settle_inc = 1'b0;
        cap_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt = ST_SETTLE;
                    start_lat = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (SETTLE == 0) begin
                    state_nxt = zero_burst ? ST_DONE : ST_RUN;
                end else if (adc_valid) begin
                    settle_inc = 1'b1;
                    if (settle_cnt == SETTLE_LAST)
                        state_nxt = zero_burst ? ST_DONE : ST_RUN;
                end
                if (cfg_stop)
                    state_nxt = ST_DONE;
            end
            ST_RUN: begin
                if (adc_valid) begin
                    cap_inc = 1'b1;
                    if (!cont_q && (cap_cnt + 16'd1 == len_q))
                        state_nxt = ST_DONE;
                end
                if (cfg_stop)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            adc_rst    <= 1'b1;
            settle_cnt <= '0;
            cap_cnt    <= '0;
            cont_q     <= 1'b0;
            len_q      <= '0;
            ovf        <= 1'b0;
        end else begin
            state   <= state_nxt;
            adc_rst <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
            if (start_lat) begin
                cont_q     <= cfg_cont;
                len_q      <= cfg_burst_len;
                settle_cnt <= '0;
                cap_cnt    <= '0;
            end else begin
                if (settle_inc)
                    settle_cnt <= settle_cnt + SW'(1);
                if (cap_inc)
                    cap_cnt <= cap_cnt + 16'd1;
            end
            // A fresh overflow outranks a clear in the same cycle.
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= adc_s_output;
    end

endmodule

// File: tb/tb_sigma_delta_adc_ctrl.sv
// Self-checking bench for sigma_delta_adc_ctrl: random sample data scored against
// expected-output queues derived from the capture rules.
module tb_sigma_delta_adc_ctrl;

    localparam int WDTH   = 16;
    localparam int SETTLE = 4;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start, cfg_stop, cfg_cont;
    logic [15:0]       cfg_burst_len;
    logic              adc_rst;
    logic [WDTH-1:0]   adc_s_output;
    logic              adc_valid;
    logic [WDTH-1:0]   m_data;
    logic              m_valid, m_ready;
    logic [3:0]        fifo_level;
    logic              busy, done, ovf, ovf_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] vals[$];

    sigma_delta_adc_ctrl #(.WDTH(WDTH), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_cont(cfg_cont),
        .cfg_burst_len(cfg_burst_len), .adc_rst(adc_rst),
        .adc_s_output(adc_s_output), .adc_valid(adc_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .busy(busy), .done(done),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Observe handshake/done at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int gap);
        adc_s_output = v;
        adc_valid    = 1'b1;
        step();
        adc_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic start(input logic c, input logic [15:0] len);
        cfg_start     = 1'b1;
        cfg_cont      = c;
        cfg_burst_len = len;
        step();
        cfg_start     = 1'b0;
        cfg_cont      = 1'b0;
        cfg_burst_len = 16'd0;
    endtask

    task automatic discard_settle();
        for (int i = 0; i < SETTLE; i++) send(16'($urandom), int'($urandom % 2));
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 64 && (m_valid || fifo_level != 0); i++) step();
        check("drain_empty", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b0;
    endtask

    task automatic compare(input string tag);
        logic [31:0] g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead_beef;
            check(tag, g, 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] v;
        int len;
        rst = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_cont = 0; cfg_burst_len = 0;
        adc_s_output = 0; adc_valid = 0; m_ready = 0; ovf_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_adc_rst", 32'(adc_rst), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        step();

        // Directed burst, samples 1..7, with a start request issued mid-capture.
        m_ready = 1'b1; done_cnt = 0;
        start(1'b0, 16'd3);
        check("burst_adc_rst_low", 32'(adc_rst), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            adc_s_output = 16'(i);
            adc_valid    = 1'b1;
            if (i == 6) begin
                cfg_start = 1'b1; cfg_cont = 1'b1; cfg_burst_len = 16'd100;
            end
            step();
            adc_valid = 1'b0; cfg_start = 1'b0; cfg_cont = 1'b0; cfg_burst_len = 16'd0;
            repeat ($urandom % 2) step();
        end
        repeat (3) step();
        check("burst_done_pulses", done_cnt, 32'd1);
        check("burst_adc_rst_idle", 32'(adc_rst), 32'd1);
        check("burst_busy", 32'(busy), 32'd0);
        drain();
        exp_q = '{16'd5, 16'd6, 16'd7};
        compare("burst_data");

        // Zero-length burst: settle runs, then straight to DONE with nothing captured.
        done_cnt = 0; m_ready = 1'b1;
        start(1'b0, 16'd0);
        for (int i = 0; i < SETTLE - 1; i++) send(16'($urandom), 0);
        check("zero_busy_settle", 32'(busy), 32'd1);
        send(16'($urandom), 0);
        check("zero_done", 32'(done), 32'd1);
        repeat (2) step();
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_level", 32'(fifo_level), 32'd0);
        check("zero_done_pulses", done_cnt, 32'd1);
        compare("zero_data");

        // Randomized bursts with random backpressure; length never exceeds DEPTH.
        for (int r = 0; r < 4; r++) begin
            done_cnt = 0;
            len = 1 + int'($urandom % DEPTH);
            vals.delete();
            for (int i = 0; i < SETTLE + len + 2; i++) vals.push_back(16'($urandom));
            for (int i = 0; i < len; i++) exp_q.push_back(vals[SETTLE + i]);
            m_ready = 1'($urandom);
            start(1'b0, 16'(len));
            foreach (vals[i]) begin
                m_ready = 1'($urandom);
                send(vals[i], int'($urandom % 3));
            end
            repeat (2) step();
            check("rand_busy", 32'(busy), 32'd0);
            check("rand_done_pulses", done_cnt, 32'd1);
            check("rand_ovf", 32'(ovf), 32'd0);
            drain();
            compare("rand_data");
        end

        // Overflow in continuous mode, clear priority, then full push+pop.
        done_cnt = 0; m_ready = 1'b0;
        start(1'b1, 16'd2);
        discard_settle();
        vals.delete();
        for (int i = 0; i < 10; i++) begin
            vals.push_back(16'($urandom));
            send(vals[i], int'($urandom % 2));
        end
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_head", 32'(m_data), 32'(vals[0]));
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        ovf_clr = 1'b1; send(16'($urandom), 0); ovf_clr = 1'b0;
        check("ovf_clr_vs_set", 32'(ovf), 32'd1);
        check("ovf_head_stable", 32'(m_data), 32'(vals[0]));
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        v = 16'($urandom);
        m_ready = 1'b1;
        send(v, 0);
        m_ready = 1'b0;
        check("full_pp_level", 32'(fifo_level), 32'd8);
        check("full_pp_ovf", 32'(ovf), 32'd0);
        check("full_pp_head", 32'(m_data), 32'(vals[1]));
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        check("ovf_stop_done", 32'(done), 32'd1);
        step();
        check("ovf_stop_busy", 32'(busy), 32'd0);
        check("ovf_no_flush", 32'(fifo_level), 32'd8);
        check("ovf_done_pulses", done_cnt, 32'd1);
        drain();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(vals[i]);
        exp_q.push_back(v);
        compare("ovf_data");

        // Stop after two captured samples with the sink stalled.
        done_cnt = 0; m_ready = 1'b0;
        start(1'b1, 16'd0);
        discard_settle();
        vals.delete();
        for (int i = 0; i < 2; i++) begin
            vals.push_back(16'($urandom));
            send(vals[i], int'($urandom % 2));
        end
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        check("stop_done", 32'(done), 32'd1);
        step();
        check("stop_adc_rst", 32'(adc_rst), 32'd1);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_level", 32'(fifo_level), 32'd2);
        drain();
        exp_q = '{vals[0], vals[1]};
        compare("stop_data");

        // Asynchronous reset in the middle of a capture.
        m_ready = 1'b0;
        start(1'b1, 16'd0);
        discard_settle();
        for (int i = 0; i < 3; i++) send(16'($urandom), 0);
        check("mid_level", 32'(fifo_level), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_adc_rst", 32'(adc_rst), 32'd1);
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_m_data", 32'(m_data), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
